// File: rtl/alu_stack_sequencer.sv
// rtl/alu_stack_sequencer.sv - data-stack owner and command sequencer for the 16-bit stack ALU
//
// Accepts one stack command at a time (PUSH / ALU / DROP / DUP) over a valid/ready
// handshake, launches TOS/NOS plus a control code to an external ALU, waits ALU_LAT
// edges, then writes the result back. Underflow/overflow are caught at accept time
// and latched into a sticky error flag.
//
// Ports:
//   c_CLOCK, c_RESET            clock, asynchronous active-high reset
//   i_CMD_VALID / o_CMD_READY   command handshake
//   i_CMD_OP                    00 PUSH, 01 ALU, 10 DROP, 11 DUP
//   i_CMD_ALUCTRL, i_CMD_DATA   ALU control code, PUSH literal
//   o_ALU_OP1/OP2/CTRL          registered operands and code to the ALU
//   i_ALU_RESULT                ALU result, captured ALU_LAT edges after launch
//   o_TOS, o_DEPTH              committed top of stack (0 when empty) and entry count
//   o_DONE                      one-cycle retire pulse
//   o_ERROR, o_ERR_CODE         sticky error, 01 underflow, 10 overflow
//   i_CLEAR_ERR                 synchronous error clear
module alu_stack_sequencer #(
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = 4,
    parameter int ALU_LAT = 1
) (
    input  logic               c_CLOCK,
    input  logic               c_RESET,
    input  logic               i_CMD_VALID,
    output logic               o_CMD_READY,
    input  logic [1:0]         i_CMD_OP,
    input  logic [3:0]         i_CMD_ALUCTRL,
    input  logic [15:0]        i_CMD_DATA,
    output logic [15:0]        o_ALU_OP1,
    output logic [15:0]        o_ALU_OP2,
    output logic [3:0]         o_ALU_CTRL,
    input  logic [15:0]        i_ALU_RESULT,
    output logic [15:0]        o_TOS,
    output logic [DEPTH_W:0]   o_DEPTH,
    output logic               o_DONE,
    output logic               o_ERROR,
    output logic [1:0]         o_ERR_CODE,
    input  logic               i_CLEAR_ERR
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_DROP = 2'b10;
    localparam logic [1:0] OP_DUP  = 2'b11;

    localparam int                 CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [DEPTH_W:0]   SP_FULL  = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0]   SP_ONE   = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W:0]   SP_TWO   = (DEPTH_W+1)'(2);

    state_t             state;
    logic [DEPTH_W:0]   sp;
    logic [CNT_W-1:0]   cnt;
    logic               bin_r;
    logic [15:0]        mem [DEPTH];

    logic [DEPTH_W:0]   sp_m1, sp_m2;
    logic [DEPTH_W-1:0] tos_idx, nos_idx, push_idx;
    logic [15:0]        tos, nos;
    logic               is_bin, need_free, underflow, overflow, accept, cmd_ok;
    logic [1:0]         need;
    logic               wen;
    logic [DEPTH_W-1:0] waddr;
    logic [15:0]        wdata;

    assign sp_m1    = sp - SP_ONE;
    assign sp_m2    = sp - SP_TWO;
    assign tos_idx  = sp_m1[DEPTH_W-1:0];
    assign nos_idx  = sp_m2[DEPTH_W-1:0];
    assign push_idx = sp[DEPTH_W-1:0];
    assign tos      = (sp == '0)    ? 16'h0000 : mem[tos_idx];
    assign nos      = (sp < SP_TWO) ? 16'h0000 : mem[nos_idx];

    assign o_TOS   = tos;
    assign o_DEPTH = sp;

    // Operand / free-slot requirements per command; ctrl[3:2]==00 marks a unary ALU op.
    always_comb begin
        is_bin    = (i_CMD_ALUCTRL[3:2] != 2'b00);
        need      = 2'd0;
        need_free = 1'b0;
        case (i_CMD_OP)
            OP_PUSH: need_free = 1'b1;
            OP_ALU:  need = is_bin ? 2'd2 : 2'd1;
            OP_DROP: need = 2'd1;
            OP_DUP: begin
                need      = 2'd1;
                need_free = 1'b1;
            end
            default: need = 2'd0;
        endcase
    end

    assign underflow = (sp < (DEPTH_W+1)'(need));
    assign overflow  = need_free && (sp == SP_FULL);
    assign accept    = i_CMD_VALID && o_CMD_READY;
    assign cmd_ok    = accept && !underflow && !overflow;

    // Single stack write port: literal/duplicate at accept, ALU result at capture.
    // A binary result lands in the NOS slot, which becomes the new TOS after the pop.
    always_comb begin
        wen   = 1'b0;
        waddr = '0;
        wdata = 16'h0000;
        if (state == IDLE && cmd_ok && i_CMD_OP == OP_PUSH) begin
            wen   = 1'b1;
            waddr = push_idx;
            wdata = i_CMD_DATA;
        end else if (state == IDLE && cmd_ok && i_CMD_OP == OP_DUP) begin
            wen   = 1'b1;
            waddr = push_idx;
            wdata = tos;
        end else if (state == EXEC && cnt == '0) begin
            wen   = 1'b1;
            waddr = bin_r ? nos_idx : tos_idx;
            wdata = i_ALU_RESULT;
        end
    end

    always_ff @(posedge c_CLOCK) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge c_CLOCK or posedge c_RESET) begin
        if (c_RESET) begin
            state       <= IDLE;
            sp          <= '0;
            cnt         <= '0;
            bin_r       <= 1'b0;
            o_CMD_READY <= 1'b0;
            o_ALU_OP1   <= 16'h0000;
            o_ALU_OP2   <= 16'h0000;
            o_ALU_CTRL  <= 4'h0;
            o_DONE      <= 1'b0;
            o_ERROR     <= 1'b0;
            o_ERR_CODE  <= 2'b00;
        end else begin
            o_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    // Ready follows the error flag one edge late, so a clear costs
                    // one extra cycle before the next command can be taken.
                    o_CMD_READY <= !o_ERROR;
                    if (o_ERROR && i_CLEAR_ERR) begin
                        o_ERROR    <= 1'b0;
                        o_ERR_CODE <= 2'b00;
                    end
                    if (accept) begin
                        if (underflow || overflow) begin
                            o_ERROR     <= 1'b1;
                            o_ERR_CODE  <= underflow ? 2'b01 : 2'b10;
                            o_CMD_READY <= 1'b0;
                        end else begin
                            case (i_CMD_OP)
                                OP_PUSH, OP_DUP: begin
                                    sp     <= sp + SP_ONE;
                                    o_DONE <= 1'b1;
                                end
                                OP_DROP: begin
                                    sp     <= sp_m1;
                                    o_DONE <= 1'b1;
                                end
                                default: begin
                                    o_ALU_OP1   <= tos;
                                    o_ALU_OP2   <= is_bin ? nos : 16'h0000;
                                    o_ALU_CTRL  <= i_CMD_ALUCTRL;
                                    bin_r       <= is_bin;
                                    cnt         <= CNT_LOAD;
                                    o_CMD_READY <= 1'b0;
                                    state       <= EXEC;
                                end
                            endcase
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        if (bin_r) begin
                            sp <= sp_m1;
                        end
                        o_DONE      <= 1'b1;
                        o_CMD_READY <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// tb/tb_alu_stack_sequencer.sv - directed self-checking bench for alu_stack_sequencer
module tb_alu_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        valid [3];
    logic [1:0]  cmd_op [3];
    logic [3:0]  cmd_ctrl [3];
    logic [15:0] cmd_data [3];
    logic        clr [3];
    logic        rdy [3];
    logic [15:0] op1 [3];
    logic [15:0] op2 [3];
    logic [3:0]  actl [3];
    logic [15:0] ares [3];
    logic [15:0] tos [3];
    logic [4:0]  dep0, dep1;
    logic [2:0]  dep2;
    logic        done [3];
    logic        err [3];
    logic [1:0]  ecode [3];

    int errors = 0;
    int checks = 0;
    int done_cnt [3] = '{0, 0, 0};
    int dc;

    always #5 clk = ~clk;

    // Reference ALU: 0101 computes OP2-OP1, 0010 negates, 0100 adds, 1110 compares.
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c);
        case (c)
            4'b0101: alu_f = b - a;
            4'b0010: alu_f = 16'h0000 - a;
            4'b0100: alu_f = a + b;
            4'b1110: alu_f = (a == b) ? 16'hFFFF : 16'h0000;
            default: alu_f = 16'h0000;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) ares[i] = alu_f(op1[i], op2[i], actl[i]);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (done[i] === 1'b1) done_cnt[i]++;
    end

    alu_stack_sequencer #(.DEPTH(16), .DEPTH_W(4), .ALU_LAT(1)) dut_a (
        .c_CLOCK(clk), .c_RESET(rst[0]), .i_CMD_VALID(valid[0]), .o_CMD_READY(rdy[0]),
        .i_CMD_OP(cmd_op[0]), .i_CMD_ALUCTRL(cmd_ctrl[0]), .i_CMD_DATA(cmd_data[0]),
        .o_ALU_OP1(op1[0]), .o_ALU_OP2(op2[0]), .o_ALU_CTRL(actl[0]), .i_ALU_RESULT(ares[0]),
        .o_TOS(tos[0]), .o_DEPTH(dep0), .o_DONE(done[0]), .o_ERROR(err[0]),
        .o_ERR_CODE(ecode[0]), .i_CLEAR_ERR(clr[0]));

    alu_stack_sequencer #(.DEPTH(16), .DEPTH_W(4), .ALU_LAT(3)) dut_b (
        .c_CLOCK(clk), .c_RESET(rst[1]), .i_CMD_VALID(valid[1]), .o_CMD_READY(rdy[1]),
        .i_CMD_OP(cmd_op[1]), .i_CMD_ALUCTRL(cmd_ctrl[1]), .i_CMD_DATA(cmd_data[1]),
        .o_ALU_OP1(op1[1]), .o_ALU_OP2(op2[1]), .o_ALU_CTRL(actl[1]), .i_ALU_RESULT(ares[1]),
        .o_TOS(tos[1]), .o_DEPTH(dep1), .o_DONE(done[1]), .o_ERROR(err[1]),
        .o_ERR_CODE(ecode[1]), .i_CLEAR_ERR(clr[1]));

    alu_stack_sequencer #(.DEPTH(4), .DEPTH_W(2), .ALU_LAT(1)) dut_c (
        .c_CLOCK(clk), .c_RESET(rst[2]), .i_CMD_VALID(valid[2]), .o_CMD_READY(rdy[2]),
        .i_CMD_OP(cmd_op[2]), .i_CMD_ALUCTRL(cmd_ctrl[2]), .i_CMD_DATA(cmd_data[2]),
        .o_ALU_OP1(op1[2]), .o_ALU_OP2(op2[2]), .o_ALU_CTRL(actl[2]), .i_ALU_RESULT(ares[2]),
        .o_TOS(tos[2]), .o_DEPTH(dep2), .o_DONE(done[2]), .o_ERROR(err[2]),
        .o_ERR_CODE(ecode[2]), .i_CLEAR_ERR(clr[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a command, waits (bounded) for ready, returns 1 time unit after the accept edge.
    task automatic send(input int i, input logic [1:0] op, input logic [3:0] ctrl, input logic [15:0] data);
        int n;
        @(negedge clk);
        cmd_op[i]   = op;
        cmd_ctrl[i] = ctrl;
        cmd_data[i] = data;
        valid[i]    = 1'b1;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(rdy[i]), 32'd1);
        @(posedge clk);
        #1;
        valid[i] = 1'b0;
    endtask

    task automatic pulse_clear(input int i);
        @(negedge clk);
        clr[i] = 1'b1;
        @(posedge clk);
        #1;
        clr[i] = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; cmd_op[i] = 2'b00;
            cmd_ctrl[i] = 4'h0; cmd_data[i] = 16'h0; clr[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 32'd0);
        check("rst_depth", 32'(dep0), 32'd0);
        check("rst_tos", 32'(tos[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_error", 32'(err[0]), 32'd0);
        check("rst_op1", 32'(op1[0]), 32'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Subtract: 5 - 3
        send(0, 2'b00, 4'h0, 16'd5);
        check("push5_done", 32'(done[0]), 32'd1);
        check("push5_tos", 32'(tos[0]), 32'd5);
        check("push5_depth", 32'(dep0), 32'd1);
        send(0, 2'b00, 4'h0, 16'd3);
        check("push3_tos", 32'(tos[0]), 32'd3);
        check("push3_depth", 32'(dep0), 32'd2);
        send(0, 2'b01, 4'b0101, 16'd0);
        check("sub_op1", 32'(op1[0]), 32'd3);
        check("sub_op2", 32'(op2[0]), 32'd5);
        check("sub_ctrl", 32'(actl[0]), 32'd5);
        check("sub_exec_ready", 32'(rdy[0]), 32'd0);
        check("sub_exec_tos", 32'(tos[0]), 32'd3);
        check("sub_exec_done", 32'(done[0]), 32'd0);
        step();
        check("sub_tos", 32'(tos[0]), 32'd2);
        check("sub_depth", 32'(dep0), 32'd1);
        check("sub_done", 32'(done[0]), 32'd1);

        // Binary op with one entry underflows
        send(0, 2'b01, 4'b0100, 16'd0);
        check("uf_error", 32'(err[0]), 32'd1);
        check("uf_code", 32'(ecode[0]), 32'd1);
        check("uf_depth", 32'(dep0), 32'd1);
        check("uf_tos", 32'(tos[0]), 32'd2);
        check("uf_done", 32'(done[0]), 32'd0);
        check("uf_ready", 32'(rdy[0]), 32'd0);
        pulse_clear(0);
        check("clr_error", 32'(err[0]), 32'd0);
        check("clr_code", 32'(ecode[0]), 32'd0);
        check("clr_ready_lag", 32'(rdy[0]), 32'd0);
        step();
        check("clr_ready", 32'(rdy[0]), 32'd1);
        check("done_count_a", 32'(done_cnt[0]), 32'd3);

        // Equality on duplicated value
        send(0, 2'b10, 4'h0, 16'd0);
        check("drop_empty_depth", 32'(dep0), 32'd0);
        check("drop_empty_tos", 32'(tos[0]), 32'd0);
        send(0, 2'b00, 4'h0, 16'd9);
        send(0, 2'b11, 4'h0, 16'd0);
        check("dup_tos", 32'(tos[0]), 32'd9);
        check("dup_depth", 32'(dep0), 32'd2);
        send(0, 2'b01, 4'b1110, 16'd0);
        step();
        check("eq_tos", 32'(tos[0]), 32'hFFFF);
        check("eq_depth", 32'(dep0), 32'd1);
        send(0, 2'b10, 4'h0, 16'd0);
        check("drop_depth", 32'(dep0), 32'd0);
        check("drop_tos", 32'(tos[0]), 32'd0);
        check("hold_op1", 32'(op1[0]), 32'd9);

        // ALU_LAT=3: negate 7
        send(1, 2'b00, 4'h0, 16'd7);
        send(1, 2'b01, 4'b0010, 16'd0);
        check("neg_k_ready", 32'(rdy[1]), 32'd0);
        check("neg_op2_unary", 32'(op2[1]), 32'd0);
        step();
        check("neg_k1_ready", 32'(rdy[1]), 32'd0);
        check("neg_k1_tos", 32'(tos[1]), 32'd7);
        step();
        check("neg_k2_ready", 32'(rdy[1]), 32'd0);
        check("neg_k2_done", 32'(done[1]), 32'd0);
        step();
        check("neg_k3_ready", 32'(rdy[1]), 32'd1);
        check("neg_k3_done", 32'(done[1]), 32'd1);
        check("neg_tos", 32'(tos[1]), 32'hFFF9);
        check("neg_depth", 32'(dep1), 32'd1);

        // Reset mid-EXEC discards the result
        send(1, 2'b00, 4'h0, 16'd1);
        send(1, 2'b00, 4'h0, 16'd2);
        send(1, 2'b01, 4'b0100, 16'd0);
        step();
        dc = done_cnt[1];
        rst[1] = 1'b1;
        #1;
        check("mrst_ready", 32'(rdy[1]), 32'd0);
        check("mrst_depth", 32'(dep1), 32'd0);
        check("mrst_tos", 32'(tos[1]), 32'd0);
        check("mrst_op1", 32'(op1[1]), 32'd0);
        check("mrst_ctrl", 32'(actl[1]), 32'd0);
        check("mrst_done", 32'(done[1]), 32'd0);
        repeat (4) @(negedge clk);
        rst[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_no_done", 32'(done_cnt[1]), 32'(dc));
        check("mrst_depth_after", 32'(dep1), 32'd0);
        check("mrst_ready_after", 32'(rdy[1]), 32'd1);

        // DEPTH=4 overflow then empty-stack DUP underflow
        for (int v = 1; v <= 4; v++) send(2, 2'b00, 4'h0, 16'(v));
        check("fill_depth", 32'(dep2), 32'd4);
        check("fill_tos", 32'(tos[2]), 32'd4);
        send(2, 2'b00, 4'h0, 16'd5);
        check("of_error", 32'(err[2]), 32'd1);
        check("of_code", 32'(ecode[2]), 32'd2);
        check("of_depth", 32'(dep2), 32'd4);
        check("of_tos", 32'(tos[2]), 32'd4);
        pulse_clear(2);
        step();
        for (int v = 0; v < 4; v++) send(2, 2'b10, 4'h0, 16'd0);
        check("empty_depth", 32'(dep2), 32'd0);
        send(2, 2'b11, 4'h0, 16'd0);
        check("dup_uf_error", 32'(err[2]), 32'd1);
        check("dup_uf_code", 32'(ecode[2]), 32'd1);
        check("dup_uf_depth", 32'(dep2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_stack_sequencer.md
Name: alu_stack_sequencer

Overview:
Sequences the 16-bit stack ALU of the Forth core. It owns the data stack, accepts one command at a time over a valid/ready handshake, and presents TOS/NOS and the 4-bit ALU control code to the ALU. It waits a fixed ALU latency, writes the ALU result back onto the stack, and flags stack underflow and overflow.

Parameters:
DEPTH, 16, number of stack entries (power of two, >= 2)
DEPTH_W, 4, log2(DEPTH)
ALU_LAT, 1, clock edges from operand launch to result capture (>= 1)

Ports:
c_CLOCK  input  1  single system clock, rising edge
c_RESET  input  1  reset, asynchronous, active-high
i_CMD_VALID  input  1  command present
o_CMD_READY  output  1  sequencer can accept a command
i_CMD_OP  input  2  00 PUSH, 01 ALU, 10 DROP, 11 DUP
i_CMD_ALUCTRL  input  4  ALU control code; used for ALU only
i_CMD_DATA  input  16  literal for PUSH
o_ALU_OP1  output  16  TOS operand to ALU
o_ALU_OP2  output  16  NOS operand to ALU
o_ALU_CTRL  output  4  control code to ALU
i_ALU_RESULT  input  16  ALU result
o_TOS  output  16  current top of stack; 0 when empty
o_DEPTH  output  DEPTH_W+1  current entry count, 0..DEPTH
o_DONE  output  1  one-cycle pulse when a command retires
o_ERROR  output  1  sticky error flag
o_ERR_CODE  output  2  00 none, 01 underflow, 10 overflow
i_CLEAR_ERR  input  1  clears o_ERROR and o_ERR_CODE

Behaviour:
- Reset (async): state IDLE, sp=0, wait counter 0, all outputs 0, o_CMD_READY=0 while c_RESET is high. Stack RAM contents are not reset. Reset during EXEC aborts the command and discards the result.
- States: IDLE, EXEC. o_CMD_READY=1 only in IDLE with o_ERROR=0.
- A command is accepted on a rising edge with i_CMD_VALID && o_CMD_READY.
- Operand need: PUSH 0 and 1 free slot; DROP 1; DUP 1 and 1 free slot; ALU unary (ctrl[3:2]=00) 1; ALU binary 2.
- Check at accept: underflow (code 01) takes priority over overflow (code 10). On failure, o_ERROR=1, o_ERR_CODE is set, stack and sp are unchanged, o_DONE=0, and state stays IDLE.
- PUSH, DROP and DUP retire on the accept edge: sp and TOS update, and o_DONE=1 for the following cycle.
- ALU accept edge k: register o_ALU_OP1=TOS, o_ALU_OP2=NOS (binary) or 0 (unary), and o_ALU_CTRL=code. Go to EXEC and load the counter.
- EXEC: operands and ctrl are held stable. At edge k+ALU_LAT, capture i_ALU_RESULT. Unary: the result replaces TOS and depth is unchanged. Binary: pop 2, push result, depth-1. Return to IDLE; o_DONE=1 for the following cycle. o_CMD_READY=0 throughout EXEC.
- Back-to-back: a new command can be accepted in the cycle o_DONE is high.
- o_ALU_* hold their last values in IDLE.
- o_TOS and o_DEPTH reflect the committed stack only; intermediate EXEC cycles show the pre-command state.
- All data is 16 bits; the result is written back unmodified, with no saturation. sp wraps are impossible by construction, because the checks block them.
- i_CLEAR_ERR is synchronous. It clears the flag on the next edge, and o_CMD_READY rises the cycle after that. i_CMD_VALID in the clear cycle is not accepted. In IDLE without an error, i_CLEAR_ERR is a no-op. While in EXEC, i_CLEAR_ERR is ignored.

Test Plan:
1. PUSH 5, PUSH 3, ALU 0101 (-), with the bench ALU returning OP2-OP1 -> o_ALU_OP1=3, o_ALU_OP2=5; o_TOS=2, o_DEPTH=1, one o_DONE pulse per command.
2. ALU_LAT=3, PUSH 7, ALU 0010 (negate) -> o_CMD_READY low for exactly 3 cycles after accept; result captured at edge k+3; o_TOS=16'hFFF9, depth 1.
3. Depth 1, ALU 0100 (+) -> o_ERROR=1, o_ERR_CODE=01, depth stays 1, TOS unchanged, no o_DONE, ready low. Pulse i_CLEAR_ERR -> ready high 2 cycles later.
4. DEPTH=4, five PUSHes of 1..5 -> 5th sets o_ERR_CODE=10, o_DEPTH=4, o_TOS=4. Empty stack then DUP -> code 01.
5. PUSH 9, DUP, ALU 1110 (=) -> o_TOS=16'hFFFF, depth 1. DROP -> depth 0, o_TOS=0.
6. Assert c_RESET mid-EXEC (ALU_LAT=3, cycle 2) -> immediate IDLE, depth 0, o_DONE never pulses, outputs 0.
